// File: rtl/mem_burst_pkg.sv
// Shared types and constants for the read-burst responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_burst_pkg;

    localparam int ADDR_W = 24;
    localparam int LEN_W  = 10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ISSUE  = ST_ISSUE,
        DRAIN  = ST_DRAIN,
        FINISH = ST_FINISH
    } state_t;

    // Word address increment; the 24-bit result wraps 0xFFFFFF -> 0x000000.
    function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/mem_burst_read_resp_if.sv
// Bundle of the rd_burst_* request/return signals and the memory read port.
// Latency: n/a (wires only).
// Backpressure: mem_ready gates strobes; the return path has no backpressure.
// Ports: master = initiator plus memory backend side, slave = burst responder.
interface mem_burst_read_resp_if
    import mem_burst_pkg::*;
#(
    parameter int DATA_BITS = 32
);
    logic                 rd_burst_req;
    logic [LEN_W-1:0]     rd_burst_len;
    logic [ADDR_W-1:0]    rd_burst_addr;
    logic                 rd_burst_data_valid;
    logic [DATA_BITS-1:0] rd_burst_data;
    logic                 rd_burst_finish;
    logic                 mem_ready;
    logic                 mem_rd_en;
    logic [ADDR_W-1:0]    mem_rd_addr;
    logic [DATA_BITS-1:0] mem_rdata;

    modport master (
        output rd_burst_req, rd_burst_len, rd_burst_addr, mem_ready, mem_rdata,
        input  rd_burst_data_valid, rd_burst_data, rd_burst_finish, mem_rd_en, mem_rd_addr
    );

    modport slave (
        input  rd_burst_req, rd_burst_len, rd_burst_addr, mem_ready, mem_rdata,
        output rd_burst_data_valid, rd_burst_data, rd_burst_finish, mem_rd_en, mem_rd_addr
    );
endinterface

// File: rtl/rd_lat_pipe.sv
// Valid shift line that tracks accepted read strobes through the memory latency.
// Latency: DEPTH cycles from in_vld to out_vld.
// Backpressure: none, shifts every cycle.
// Ports: mem_clk, rst_n (async active-low), in_vld, out_vld.
module rd_lat_pipe #(
    parameter int DEPTH = 2
) (
    input  logic mem_clk,
    input  logic rst_n,
    input  logic in_vld,
    output logic out_vld
);
    logic [DEPTH-1:0] sr;

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr[0] <= in_vld;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign out_vld = sr[DEPTH-1];
endmodule

// File: rtl/mem_burst_read_resp.sv
// Read-burst responder: walks a word-addressed synchronous memory for one burst.
// Latency: first beat READ_LATENCY+2 cycles after acceptance; finish 1 cycle after last beat.
// Backpressure: mem_ready stalls strobe issue only; returned data is never stalled.
// Ports: mem_clk, rst_n (async active-low), bus (slave side of mem_burst_read_resp_if).
module mem_burst_read_resp
    import mem_burst_pkg::*;
#(
    parameter int MEM_DATA_BITS = 32,
    parameter int READ_LATENCY  = 2
) (
    input  logic                  mem_clk,
    input  logic                  rst_n,
    mem_burst_read_resp_if.slave  bus
);
    state_t                   state;
    state_t                   state_nxt;
    logic [ADDR_W-1:0]        addr_cnt;
    logic [LEN_W-1:0]         issue_left;
    logic [LEN_W-1:0]         ret_left;
    logic                     accept;
    logic                     strobe;
    logic                     ret_vld;
    logic                     data_vld;
    logic [MEM_DATA_BITS-1:0] data;
    logic                     finish;

    assign accept = (state == IDLE) && bus.rd_burst_req;
    assign strobe = (state == ISSUE) && bus.mem_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.rd_burst_req) begin
                    state_nxt = (bus.rd_burst_len == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                if (strobe && issue_left == LEN_W'(1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // data_vld is the registered beat, so finish lands one cycle after it.
                if (data_vld && ret_left == LEN_W'(1)) begin
                    state_nxt = FINISH;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt   <= '0;
            issue_left <= '0;
            ret_left   <= '0;
        end else if (accept) begin
            addr_cnt   <= bus.rd_burst_addr;
            issue_left <= bus.rd_burst_len;
            ret_left   <= bus.rd_burst_len;
        end else begin
            if (strobe) begin
                addr_cnt   <= addr_next(addr_cnt);
                issue_left <= issue_left - LEN_W'(1);
            end
            if (data_vld && ret_left != '0) begin
                ret_left <= ret_left - LEN_W'(1);
            end
        end
    end

    rd_lat_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_lat_pipe (
        .mem_clk (mem_clk),
        .rst_n   (rst_n),
        .in_vld  (strobe),
        .out_vld (ret_vld)
    );

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            data_vld <= 1'b0;
            data     <= '0;
            finish   <= 1'b0;
        end else begin
            data_vld <= ret_vld;
            if (ret_vld) begin
                data <= bus.mem_rdata;
            end
            finish <= (state_nxt == FINISH);
        end
    end

    assign bus.mem_rd_en           = strobe;
    assign bus.mem_rd_addr         = addr_cnt;
    assign bus.rd_burst_data_valid = data_vld;
    assign bus.rd_burst_data       = data;
    assign bus.rd_burst_finish     = finish;
endmodule

// File: tb/tb_mem_burst_read_resp.sv
module tb_mem_burst_read_resp;
    import mem_burst_pkg::*;

    localparam int DW = 32;
    localparam int RL = 2;

    typedef struct {
        int len;
        int t_acc;
        bit b2b;
    } burst_t;

    logic mem_clk = 1'b0;
    logic rst_n   = 1'b0;
    always #5 mem_clk = ~mem_clk;

    mem_burst_read_resp_if #(.DATA_BITS(DW)) bus ();

    mem_burst_read_resp #(
        .MEM_DATA_BITS (DW),
        .READ_LATENCY  (RL)
    ) dut (
        .mem_clk (mem_clk),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] ram_word(input logic [ADDR_W-1:0] a);
        return {8'h00, a};
    endfunction

    // ---------------- memory backend model ----------------
    logic [DW-1:0] memq [RL];
    always @(posedge mem_clk) begin
        memq[0] <= bus.mem_rd_en ? ram_word(bus.mem_rd_addr) : DW'($urandom);
        for (int i = 1; i < RL; i++) memq[i] <= memq[i-1];
    end
    assign bus.mem_rdata = memq[RL-1];

    int edge_cnt = 0;
    always @(posedge mem_clk) edge_cnt <= edge_cnt + 1;

    // mem_ready driven just after each edge: pattern first, then random or held high
    bit rdy_q[$];
    bit pend_pat[$];
    bit rdy_rand = 1'b0;
    always @(posedge mem_clk) begin
        #1;
        if (rdy_q.size() > 0)  bus.mem_ready = rdy_q.pop_front();
        else if (rdy_rand)     bus.mem_ready = 1'($urandom_range(0, 1));
        else                   bus.mem_ready = 1'b1;
    end

    // ---------------- scoreboard / monitor ----------------
    logic [ADDR_W-1:0] addr_q[$];
    logic [DW-1:0]     exp_q[$];
    burst_t            burst_q[$];
    burst_t            mb;
    int                beats = 0;
    int                last_cyc = 0;
    int                fin_cnt = 0;
    logic [DW-1:0]     hold_val = '0;

    always @(negedge mem_clk) begin
        int cyc;
        cyc = edge_cnt + 1;
        if (!rst_n) begin
            beats    = 0;
            hold_val = '0;
        end else begin
            if (bus.mem_rd_en) begin
                check("strobe_needs_ready", bus.mem_ready, 1);
                if (addr_q.size() == 0) check("unexpected_strobe", 1, 0);
                else                    check("strobe_addr", bus.mem_rd_addr, addr_q.pop_front());
            end
            if (bus.rd_burst_data_valid) begin
                if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
                else                   check("beat_data", bus.rd_burst_data, exp_q.pop_front());
                if (beats == 0 && burst_q.size() > 0 && burst_q[0].b2b)
                    check("first_beat_cycle", cyc, burst_q[0].t_acc + RL + 2);
                check("finish_during_beat", bus.rd_burst_finish, 0);
                beats++;
                last_cyc = cyc;
                hold_val = bus.rd_burst_data;
            end else begin
                check("data_hold", bus.rd_burst_data, hold_val);
            end
            if (bus.rd_burst_finish) begin
                if (burst_q.size() == 0) begin
                    check("unexpected_finish", 1, 0);
                end else begin
                    mb = burst_q.pop_front();
                    check("beat_count", beats, mb.len);
                    if (mb.len > 0) check("finish_after_last_beat", cyc, last_cyc + 1);
                    if (mb.b2b)
                        check("finish_cycle", cyc,
                              (mb.len == 0) ? mb.t_acc + 1 : mb.t_acc + RL + mb.len + 2);
                end
                beats = 0;
                fin_cnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    // early=1: req raised in the finish cycle of the previous burst, so it is
    // accepted on the second following edge (first one lands in FINISH).
    task automatic issue_burst(input int len, input logic [ADDR_W-1:0] addr,
                               input bit b2b, input bit early, input int gap);
        int t;
        if (!early) repeat (gap) @(negedge mem_clk);
        t = early ? edge_cnt + 2 : edge_cnt + 1;
        bus.rd_burst_req  = 1'b1;
        bus.rd_burst_len  = LEN_W'(len);
        bus.rd_burst_addr = addr;
        for (int i = 0; i < len; i++) begin
            addr_q.push_back(ADDR_W'(addr + ADDR_W'(i)));
            exp_q.push_back(ram_word(ADDR_W'(addr + ADDR_W'(i))));
        end
        burst_q.push_back('{len, t, b2b});
        if (early) @(posedge mem_clk);
        @(posedge mem_clk);
        while (pend_pat.size() > 0) rdy_q.push_back(pend_pat.pop_front());
        @(negedge mem_clk);
        // later changes to len/addr must be ignored
        bus.rd_burst_len  = LEN_W'($urandom);
        bus.rd_burst_addr = ADDR_W'($urandom);
        @(negedge mem_clk);
        bus.rd_burst_req  = 1'b0;
    endtask

    task automatic wait_finish(input int target);
        int g;
        g = 0;
        while (fin_cnt < target && g < 3000) begin
            @(negedge mem_clk);
            #1;
            g++;
        end
        if (fin_cnt < target) check("burst_timeout", fin_cnt, target);
    endtask

    task automatic run_burst(input int len, input logic [ADDR_W-1:0] addr,
                             input bit b2b, input bit early, input int gap);
        int target;
        target = fin_cnt + 1;
        issue_burst(len, addr, b2b, early, gap);
        wait_finish(target);
    endtask

    initial begin
        int g;
        bus.rd_burst_req  = 1'b0;
        bus.rd_burst_len  = '0;
        bus.rd_burst_addr = '0;
        bus.mem_ready     = 1'b1;

        #3;
        check("rst_data_valid", bus.rd_burst_data_valid, 0);
        check("rst_data",       bus.rd_burst_data, 0);
        check("rst_finish",     bus.rd_burst_finish, 0);
        check("rst_mem_rd_en",  bus.mem_rd_en, 0);
        check("rst_mem_rd_addr", bus.mem_rd_addr, 0);
        repeat (3) @(negedge mem_clk);
        rst_n = 1'b1;

        run_burst(4, 24'h000100, 1'b1, 1'b0, 2);
        run_burst(1, 24'h000000, 1'b1, 1'b0, 2);
        run_burst(0, 24'h000040, 1'b1, 1'b1, 0);
        pend_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        run_burst(3, 24'h000300, 1'b0, 1'b0, 2);
        run_burst(4, 24'hFFFFFE, 1'b1, 1'b0, 3);

        // reset in the middle of a burst
        issue_burst(8, 24'h000200, 1'b1, 1'b0, 2);
        g = 0;
        while (beats < 2 && g < 200) begin
            @(negedge mem_clk);
            #1;
            g++;
        end
        check("reach_two_beats", beats, 2);
        rst_n = 1'b0;
        addr_q.delete();
        exp_q.delete();
        burst_q.delete();
        rdy_q.delete();
        #1;
        check("midrst_data_valid", bus.rd_burst_data_valid, 0);
        check("midrst_data",       bus.rd_burst_data, 0);
        check("midrst_finish",     bus.rd_burst_finish, 0);
        check("midrst_mem_rd_en",  bus.mem_rd_en, 0);
        check("midrst_mem_rd_addr", bus.mem_rd_addr, 0);
        repeat (3) @(negedge mem_clk);
        rst_n = 1'b1;
        run_burst(2, 24'h005000, 1'b1, 1'b0, 2);

        // randomized bursts
        for (int k = 0; k < 16; k++) begin
            int len;
            logic [ADDR_W-1:0] addr;
            bit rnd;
            len  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 40));
            addr = ($urandom_range(0, 3) == 0) ? ADDR_W'(24'hFFFFF0 + $urandom_range(0, 15))
                                               : ADDR_W'($urandom);
            rnd  = 1'($urandom_range(0, 1));
            rdy_rand = rnd;
            run_burst(len, addr, !rnd, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
        end
        rdy_rand = 1'b0;

        repeat (RL + 4) @(negedge mem_clk);
        check("leftover_strobes", addr_q.size(), 0);
        check("leftover_beats",   exp_q.size(), 0);
        check("leftover_bursts",  burst_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
